// File: rtl/msg_scroller_if.sv
// Control and display bundle for the scrolling message driver.
// master drives the controls; slave is the scroller itself.
interface msg_scroller_if;
   logic       en;
   logic       step;
   logic       dir;
   logic [3:0] letra;
   logic [3:0] digit_sel;
   logic [3:0] pos;
   logic       wrap;

   modport master (
      output en, step, dir,
      input  letra, digit_sel, pos, wrap
   );

   modport slave (
      input  en, step, dir,
      output letra, digit_sel, pos, wrap
   );
endinterface

// File: rtl/msg_scroller.sv
// Scrolls a fixed 12-letter message across a 4-digit multiplexed
// display, auto-timed or stepped by hand.
module msg_scroller #(
   parameter int SCROLL_DIV = 10_000_000,
   parameter int MUX_DIV    = 10_000
) (
   input logic          clk,
   input logic          reset,
   msg_scroller_if.slave bus
);
   localparam int SW = $clog2(SCROLL_DIV);
   localparam int MW = $clog2(MUX_DIV);
   localparam logic [SW-1:0] SCROLL_TOP = SW'(SCROLL_DIV - 1);
   localparam logic [MW-1:0] MUX_TOP    = MW'(MUX_DIV - 1);

   logic [SW-1:0] scnt, scnt_n;
   logic [MW-1:0] mcnt, mcnt_n;
   logic [3:0]    head, head_n;
   logic [1:0]    d, d_n;
   logic          step_q;
   logic          adv;
   logic          wrap_n;
   logic [4:0]    sum;
   logic [3:0]    idx;
   logic [3:0]    code;

   always_comb begin
      scnt_n = scnt;
      mcnt_n = mcnt + 1'b1;
      head_n = head;
      d_n    = d;
      adv    = 1'b0;
      wrap_n = 1'b0;

      // manual steps only count while auto-scroll is paused
      if (bus.en) begin
         if (scnt == SCROLL_TOP) begin
            scnt_n = '0;
            adv    = 1'b1;
         end else begin
            scnt_n = scnt + 1'b1;
         end
      end else if (bus.step && !step_q) begin
         adv = 1'b1;
      end

      if (mcnt == MUX_TOP) begin
         mcnt_n = '0;
         d_n    = d + 2'd1;
      end

      if (adv) begin
         if (bus.dir) begin
            if (head == 4'd0) begin
               head_n = 4'd11;
               wrap_n = 1'b1;
            end else begin
               head_n = head - 4'd1;
            end
         end else begin
            if (head == 4'd11) begin
               head_n = 4'd0;
               wrap_n = 1'b1;
            end else begin
               head_n = head + 4'd1;
            end
         end
      end
   end

   always_comb begin
      sum = {1'b0, head_n} + {3'b000, d_n};
      idx = (sum >= 5'd12) ? 4'(sum - 5'd12) : sum[3:0];
   end

   // A,B,D,U,L,-,J,O,S,E map to codes 0..9; the tail is blank
   always_comb begin
      code = 4'd15;
      case (idx)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
         4'd5, 4'd6, 4'd7, 4'd8, 4'd9: code = idx;
         default:                      code = 4'd15;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         scnt          <= '0;
         mcnt          <= '0;
         head          <= 4'd0;
         d             <= 2'd0;
         step_q        <= 1'b0;
         bus.letra     <= 4'd0;
         bus.digit_sel <= 4'b0001;
         bus.pos       <= 4'd0;
         bus.wrap      <= 1'b0;
      end else begin
         scnt          <= scnt_n;
         mcnt          <= mcnt_n;
         head          <= head_n;
         d             <= d_n;
         step_q        <= bus.step;
         bus.letra     <= code;
         bus.digit_sel <= 4'b0001 << d_n;
         bus.pos       <= head_n;
         bus.wrap      <= wrap_n;
      end
   end
endmodule

// File: tb/tb_msg_scroller.sv
// Directed checks of msg_scroller with short dividers
// (SCROLL_DIV=8, MUX_DIV=2).
module tb_msg_scroller;
   typedef struct {
      logic       rst;
      logic       en;
      logic       step;
      logic       dir;
      int         n;
      logic [3:0] pos;
      logic [3:0] letra;
      logic [3:0] dsel;
      logic       wrap;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   vec_t vt[$];

   msg_scroller_if bus ();

   msg_scroller #(
      .SCROLL_DIV(8),
      .MUX_DIV   (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic e, input logic s,
                      input logic dr, input int n, input int p,
                      input int l, input int ds, input logic w);
      vec_t v;
      v.rst = r; v.en = e; v.step = s; v.dir = dr; v.n = n;
      v.pos = 4'(p); v.letra = 4'(l); v.dsel = 4'(ds); v.wrap = w;
      vt.push_back(v);
   endtask

   initial begin
      int wc;
      int wat;
      int bad;

      bus.en = 1'b0;
      bus.step = 1'b0;
      bus.dir = 1'b0;

      // forward run: first advance, digit letters, coincident terminals, wrap
      add(1, 0, 0, 0,  1,  0,  0, 1, 0);
      add(0, 1, 0, 0,  7,  0,  3, 8, 0);
      add(0, 1, 0, 0,  1,  1,  1, 1, 0);
      add(0, 1, 0, 0,  2,  1,  2, 2, 0);
      add(0, 1, 0, 0,  2,  1,  3, 4, 0);
      add(0, 1, 0, 0,  2,  1,  4, 8, 0);
      add(0, 1, 0, 0, 25,  4,  7, 8, 0);
      add(0, 1, 0, 0,  1,  5,  5, 1, 0);
      add(0, 1, 0, 0, 55, 11,  2, 8, 0);
      add(0, 1, 0, 0,  1,  0,  0, 1, 1);
      add(0, 1, 0, 0,  1,  0,  0, 1, 0);
      // reverse from reset wraps to 11
      add(1, 0, 0, 0,  1,  0,  0, 1, 0);
      add(0, 1, 0, 1,  8, 11, 15, 1, 1);
      add(0, 1, 0, 1,  1, 11, 15, 1, 0);
      add(0, 1, 0, 1,  1, 11,  0, 2, 0);
      add(0, 1, 0, 1,  2, 11,  1, 4, 0);
      add(0, 1, 0, 1,  2, 11,  2, 8, 0);
      // reset mid-run, including on an advance edge
      add(1, 0, 0, 0,  1,  0,  0, 1, 0);
      add(0, 1, 0, 0, 60,  7,  9, 4, 0);
      add(1, 1, 0, 0,  1,  0,  0, 1, 0);
      add(0, 1, 0, 0, 63,  7, 15, 8, 0);
      add(1, 1, 0, 0,  1,  0,  0, 1, 0);
      // manual steps, step high out of reset, freeze and ignored step
      add(1, 0, 1, 0,  1,  0,  0, 1, 0);
      add(0, 0, 1, 0,  5,  1,  3, 4, 0);
      add(0, 0, 0, 0,  5,  1,  2, 2, 0);
      add(0, 0, 1, 0,  5,  2,  5, 8, 0);
      add(0, 0, 0, 0,  5,  2,  4, 4, 0);
      add(0, 0, 1, 0,  5,  3,  3, 1, 0);
      add(0, 1, 0, 0,  3,  3,  5, 4, 0);
      add(0, 0, 0, 0,  4,  3,  3, 1, 0);
      add(0, 1, 1, 0,  2,  3,  4, 2, 0);
      add(0, 1, 0, 0,  2,  3,  5, 4, 0);
      add(0, 1, 0, 0,  1,  4,  6, 4, 0);

      #1;
      foreach (vt[i]) begin
         reset = vt[i].rst;
         bus.en = vt[i].en;
         bus.step = vt[i].step;
         bus.dir = vt[i].dir;
         repeat (vt[i].n) @(posedge clk);
         #1;
         chk($sformatf("v%0d_pos", i), int'(bus.pos), int'(vt[i].pos));
         chk($sformatf("v%0d_letra", i), int'(bus.letra), int'(vt[i].letra));
         chk($sformatf("v%0d_dsel", i), int'(bus.digit_sel), int'(vt[i].dsel));
         chk($sformatf("v%0d_wrap", i), int'(bus.wrap), int'(vt[i].wrap));
      end

      // full forward lap: single one-cycle wrap, one-hot digits, head in range
      reset = 1'b1;
      bus.en = 1'b0;
      bus.step = 1'b0;
      bus.dir = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.en = 1'b1;
      wc = 0;
      wat = -1;
      bad = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (bus.wrap) begin
            wc++;
            wat = c;
         end
         if (!$onehot(bus.digit_sel) || bus.pos > 4'd11) bad++;
      end
      chk("lap_wrap_count", wc, 1);
      chk("lap_wrap_cycle", wat, 96);
      chk("lap_shape_errs", bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/msg_scroller.md
MSG_SCROLLER -- requirements
Module: msg_scroller

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 10_000_000, meaning clock cycles per scroll step (minimum 2).
REQ-002 SHALL have parameter MUX_DIV, default 10_000, meaning clock cycles per display digit slot (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: 1 = auto-scroll, 0 = paused.
REQ-006 SHALL have port step, input, 1 bit: manual advance request, level signal, rising-edge detected internally.
REQ-007 SHALL have port dir, input, 1 bit: 0 = forward (head increments), 1 = reverse (head decrements).
REQ-008 SHALL have port letra, output, 4 bits: letter code for the currently selected digit, consumed by the downstream 7-segment letter decoder.
REQ-009 SHALL have port digit_sel, output, 4 bits: one-hot active-high digit enable, bit 0 = leftmost digit.
REQ-010 SHALL have port pos, output, 4 bits: current head index into the message.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse when head wraps.

Function
REQ-012 SHALL hold a fixed 12-entry message, index 0..11: codes 0,1,2,3,4,5,6,7,8,9,15,15 (A,B,D,U,L,-,J,O,S,E,blank,blank); code 15 is blank, and the downstream decoder drives all segments off for codes 10..15.
REQ-013 SHALL keep a scroll counter 0..SCROLL_DIV-1 that increments only while en=1; at SCROLL_DIV-1 it returns to 0 and generates one advance.
REQ-014 SHALL freeze the scroll counter (hold its value, no clear) while en=0.
REQ-015 SHALL register step and detect a rising edge (step=1, previous=0); the edge generates one advance only when en=0, and is ignored when en=1.
REQ-016 Advance SHALL be: dir=0 -> head=(head+1) mod 12; dir=1 -> head=(head+11) mod 12; dir is sampled in the advance cycle; a dir change does not clear any counter.
REQ-017 SHALL drive wrap=1 for exactly the cycle after an advance from 11 to 0 (forward) or from 0 to 11 (reverse), and 0 otherwise.
REQ-018 SHALL keep a mux counter 0..MUX_DIV-1 that runs regardless of en; at terminal count, digit index d (0..3) advances to (d+1) mod 4.
REQ-019 letra SHALL be registered, equal to msg[(head+d) mod 12], using head and d values after the current cycle's updates, and valid one cycle after any change of head or d.
REQ-020 digit_sel SHALL be registered and updated in the same cycle as letra, so that digit_sel = 1<<d always matches letra; exactly one bit is set at all times.
REQ-021 pos SHALL equal head, registered.
REQ-022 If a scroll advance and a digit advance fall in the same cycle, both SHALL take effect, and the next-cycle outputs SHALL reflect the new head and the new d together.
REQ-023 Head arithmetic SHALL never produce values 12..15; the modulo is explicit, not 4-bit wrap.

Reset
REQ-024 While reset=1 at a clock edge: scroll counter=0, mux counter=0, head=0, d=0, step history=0.
REQ-025 While reset=1 at a clock edge, outputs SHALL be letra=0, digit_sel=4'b0001, pos=0, wrap=0.
REQ-026 Reset asserted mid-operation SHALL override any pending advance in that cycle.
REQ-027 After reset, a step already high in the first cycle SHALL count as a rising edge.

Verification (SCROLL_DIV=8, MUX_DIV=2)
REQ-028 Reset, then en=1 and dir=0 for 8 cycles -> pos goes 0->1; after further digit cycling, letra sequence per digit_sel 0001,0010,0100,1000 is 1,2,3,4.
REQ-029 en=1, dir=0, run 96 cycles from reset -> pos returns to 0 and wrap pulses exactly once, one cycle wide, at the 11->0 transition.
REQ-030 From reset, en=1 and dir=1 -> first advance gives pos=11 with a wrap pulse; with head=11, letra shows 15,0,1,2 across digits 0..3.
REQ-031 en=0 with step pulsed 3 times (high 5 cycles each) -> pos=3; step pulses with en=1 and the scroll counter mid-count -> no extra advance, and the count resumes from its frozen value.
REQ-032 Assert reset for 1 cycle while pos=7 and d=2 -> next cycle pos=0, digit_sel=0001, letra=0, wrap=0.
REQ-033 With both counters at terminal count in the same cycle (head=4, d=3 -> head=5, d=0) -> next cycle letra=5 (msg[5]), digit_sel=0001.
